aes_round_sequencer: RTL and testbench

Iterative AES-128 encryption engine: one shared round datapath (Top_Sbox, Shift_Rows, Top_Mixed_Columns) is reused across all ten rounds, one round per clock, under control of a round counter and FSM. Round keys come from one Top_Key_Scheduler instance fed by a registered key and are selected by the round counter. It sits beside the fully unrolled combinational encryptor as the low-area alternative, with valid/ready handshakes on both the input and output sides.

---
 rtl/aes_round_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor: one shared round datapath reused for rounds 1..10,
// one round per clock, with valid/ready handshakes on both sides.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; 0 maps to 0 for free.
    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign y = sbox_f(a);
endmodule

module aes_mix_column (
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] b0, b1, b2, b3;

    assign b0 = col_i[31:24];
    assign b1 = col_i[23:16];
    assign b2 = col_i[15:8];
    assign b3 = col_i[7:0];

    assign col_o[31:24] = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
    assign col_o[23:16] = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
    assign col_o[15:8]  = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
    assign col_o[7:0]   = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
endmodule

module aes_key_round #(
    parameter logic [7:0] RCON = 8'h01
) (
    input  logic [127:0] k_in,
    output logic [127:0] k_out
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w, sub_w, t_w;
    logic [31:0] n0, n1, n2, n3;

    assign w0    = k_in[127:96];
    assign w1    = k_in[95:64];
    assign w2    = k_in[63:32];
    assign w3    = k_in[31:0];
    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes_sbox u_sbox (
            .a (rot_w[31-8*i -: 8]),
            .y (sub_w[31-8*i -: 8])
        );
    end

    assign t_w   = sub_w ^ {RCON, 24'h000000};
    assign n0    = w0 ^ t_w;
    assign n1    = w1 ^ n0;
    assign n2    = w2 ^ n1;
    assign n3    = w3 ^ n2;
    assign k_out = {n0, n1, n2, n3};
endmodule

module aes_key_scheduler (
    input  logic [127:0]  key,
    output logic [1279:0] rk_flat
);
    logic [10:0][127:0] chain;

    assign chain[0] = key;

    for (genvar r = 1; r <= 10; r++) begin : g_rnd
        localparam logic [7:0] RC = (r == 9) ? 8'h1b : (r == 10) ? 8'h36 : 8'(1 << (r - 1));
        aes_key_round #(.RCON(RC)) u_kr (
            .k_in  (chain[r-1]),
            .k_out (chain[r])
        );
        assign rk_flat[128*(r-1) +: 128] = chain[r];
    end
endmodule

module aes_round_sequencer (
    input  logic         clk,
    input  logic         rst,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [0:127] PT,
    input  logic [0:127] KEY,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [0:127] CT,
    output logic [3:0]   ROUND
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [127:0]  state_q, state_d;
    logic [127:0]  key_q, key_d;
    logic [127:0]  ct_q, ct_d;
    logic [3:0]    rnd_q, rnd_d;

    logic [127:0]  sub_w, shift_w, mix_w, rk_w, round_w;
    logic [1279:0] rk_flat;
    logic          last_rnd;

    // Byte i of the block sits at [127-8*i -: 8]; bytes run column-major.
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .a (state_q[127-8*i -: 8]),
            .y (sub_w[127-8*i -: 8])
        );
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign shift_w[127-8*(r+4*c) -: 8] = sub_w[127-8*(r+4*((c+r)%4)) -: 8];
        end
        aes_mix_column u_mix (
            .col_i (shift_w[127-32*c -: 32]),
            .col_o (mix_w[127-32*c -: 32])
        );
    end

    aes_key_scheduler u_ks (
        .key     (key_q),
        .rk_flat (rk_flat)
    );

    always_comb begin
        rk_w = '0;
        for (int r = 1; r <= 10; r++) begin
            if (rnd_q == 4'(r)) rk_w = rk_flat[128*(r-1) +: 128];
        end
    end

    assign last_rnd = (rnd_q == 4'd10);
    assign round_w  = (last_rnd ? shift_w : mix_w) ^ rk_w;

    always_ff @(posedge clk) begin
        if (rst) fsm_q <= IDLE;
        else     fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE:    if (IN_VALID)  fsm_d = RUN;
            RUN:     if (last_rnd)  fsm_d = DONE;
            DONE:    if (OUT_READY) fsm_d = IDLE;
            default:                fsm_d = IDLE;
        endcase
    end

    always_comb begin
        IN_READY  = (fsm_q == IDLE);
        OUT_VALID = (fsm_q == DONE);
        CT        = ct_q;
        ROUND     = rnd_q;
    end

    // Inputs are captured only on the accept edge; CT only moves on the final round.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        ct_d    = ct_q;
        rnd_d   = rnd_q;
        unique case (fsm_q)
            IDLE: begin
                if (IN_VALID) begin
                    state_d = PT ^ KEY;
                    key_d   = KEY;
                    rnd_d   = 4'd1;
                end
            end
            RUN: begin
                state_d = round_w;
                if (last_rnd) begin
                    ct_d  = round_w;
                    rnd_d = 4'd0;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            key_q   <= '0;
            ct_q    <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            ct_q    <= ct_d;
            rnd_q   <= rnd_d;
        end
    end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Randomized bench for aes_round_sequencer against a byte-array AES-128 model.

module tb_aes_round_sequencer;
    logic         clk = 1'b0;
    logic         rst;
    logic         IN_VALID;
    logic         IN_READY;
    logic [0:127] PT;
    logic [0:127] KEY;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [0:127] CT;
    logic [3:0]   ROUND;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] sbox_tab [256];

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_round_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .PT        (PT),
        .KEY       (KEY),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .CT        (CT),
        .ROUND     (ROUND)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // GF(2^8) product, Horner form from the top bit of b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            if (b[i]) p = p ^ a;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] cst;
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
            sbox_tab[x] = s;
        end
    endtask

    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [7:0]  a0, a1, a2, a3;
        logic [127:0] out;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int i = 0; i < 4; i++)  w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]],
                       sbox_tab[tmp[31:24]]} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) s[4*c+j] = s[4*c+j] ^ w[c][31-8*j -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
            for (int i = 0; i < 16; i++) s[i] = t[i];
            if (rd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) s[4*c+j] = s[4*c+j] ^ w[4*rd+c][31-8*j -: 8];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    // Called right after the accept edge; walks rounds 1..10 and checks the result.
    task automatic run_rounds(input string tag, input logic [127:0] exp, input bit scramble);
        for (int k = 1; k <= 10; k++) begin
            chk({tag, "_round"}, 128'(ROUND), 128'(k));
            chk({tag, "_busy_ovalid"}, 128'(OUT_VALID), 128'(0));
            chk({tag, "_busy_iready"}, 128'(IN_READY), 128'(0));
            if (scramble) begin
                PT  = rnd128();
                KEY = rnd128();
            end
            step();
        end
        chk({tag, "_ovalid"}, 128'(OUT_VALID), 128'(1));
        chk({tag, "_ct"}, CT, exp);
        chk({tag, "_done_round"}, 128'(ROUND), 128'(0));
    endtask

    logic [127:0] pts  [50];
    logic [127:0] keys [50];
    logic [127:0] exps [50];
    logic [127:0] pt2, key2, ct_hold;

    initial begin
        build_sbox();

        rst = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b1;
        PT = rnd128(); KEY = rnd128();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_iready", 128'(IN_READY), 128'(1));
            chk("rst_ovalid", 128'(OUT_VALID), 128'(0));
            chk("rst_ct", CT, 128'(0));
            chk("rst_round", 128'(ROUND), 128'(0));
            PT = rnd128(); KEY = rnd128();
        end
        rst = 1'b0; IN_VALID = 1'b0;
        step();
        chk("idle_iready", 128'(IN_READY), 128'(1));

        PT = C1_PT; KEY = C1_KEY; IN_VALID = 1'b1; OUT_READY = 1'b1;
        step();
        IN_VALID = 1'b0;
        run_rounds("c1", C1_CT, 1'b0);
        chk("c1_vs_model", CT, ref_enc(C1_PT, C1_KEY));
        step();
        chk("c1_xfer_iready", 128'(IN_READY), 128'(1));
        chk("c1_xfer_ovalid", 128'(OUT_VALID), 128'(0));

        OUT_READY = 1'b0; PT = B_PT; KEY = B_KEY; IN_VALID = 1'b1;
        step();
        run_rounds("appb", B_CT, 1'b1);
        ct_hold = CT;
        for (int i = 0; i < 20; i++) begin
            PT = rnd128(); KEY = rnd128();
            step();
            chk("bp_ovalid", 128'(OUT_VALID), 128'(1));
            chk("bp_ct", CT, B_CT);
            chk("bp_iready", 128'(IN_READY), 128'(0));
            chk("bp_round", 128'(ROUND), 128'(0));
        end
        chk("bp_ct_stable", CT, ct_hold);
        pt2 = rnd128(); key2 = rnd128();
        PT = pt2; KEY = key2; OUT_READY = 1'b1;
        step();
        chk("bp_rel_iready", 128'(IN_READY), 128'(1));
        chk("bp_rel_ovalid", 128'(OUT_VALID), 128'(0));
        OUT_READY = 1'b0;
        step();
        IN_VALID = 1'b0;
        run_rounds("bp2", ref_enc(pt2, key2), 1'b0);
        OUT_READY = 1'b1;
        step();
        chk("bp2_idle", 128'(IN_READY), 128'(1));

        PT = rnd128(); KEY = rnd128(); IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("mid_round5", 128'(ROUND), 128'(5));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_iready", 128'(IN_READY), 128'(1));
        chk("mid_ovalid", 128'(OUT_VALID), 128'(0));
        chk("mid_ct", CT, 128'(0));
        chk("mid_round", 128'(ROUND), 128'(0));
        step();
        chk("mid_no_emit", 128'(OUT_VALID), 128'(0));
        PT = C1_PT; KEY = C1_KEY; IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        run_rounds("c1_rst", C1_CT, 1'b0);
        step();

        for (int i = 0; i < 50; i++) begin
            pts[i]  = rnd128();
            keys[i] = rnd128();
            exps[i] = ref_enc(pts[i], keys[i]);
        end
        begin
            int cyc = 0, acc = 0, got = 0, last_acc = -1;
            bit accepting;
            OUT_READY = 1'b1;
            while (got < 50 && cyc < 1500) begin
                if (acc < 50) begin
                    PT = pts[acc]; KEY = keys[acc]; IN_VALID = 1'b1;
                end else begin
                    IN_VALID = 1'b0;
                end
                accepting = IN_READY && IN_VALID;
                if (OUT_VALID) begin
                    chk("b2b_ct", CT, exps[got]);
                    got++;
                end
                step();
                if (accepting) begin
                    if (last_acc >= 0) chk("b2b_spacing", 128'(cyc - last_acc), 128'(12));
                    last_acc = cyc;
                    acc++;
                end
                cyc++;
            end
            chk("b2b_count", 128'(got), 128'(50));
            IN_VALID = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
